// File: rtl/cpu_run_ctrl_if.sv
// Debug/run-control bundle between the run controller and its host (debugger + core taps).
interface cpu_run_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 run_pi;
    logic                 step_pi;
    logic                 halt_pi;
    logic                 bp_en_pi;
    logic [15:0]          bp_addr_pi;
    logic [15:0]          pc_pi;
    logic [15:0]          instr_pi;
    logic                 clear_counts_pi;
    logic                 clock_enable_po;
    logic [1:0]           state_po;
    logic                 halted_po;
    logic [1:0]           halt_cause_po;
    logic [CNT_WIDTH-1:0] cycle_count_po;
    logic [CNT_WIDTH-1:0] instr_count_po;

    modport master (
        output run_pi, step_pi, halt_pi, bp_en_pi, bp_addr_pi, pc_pi, instr_pi, clear_counts_pi,
        input  clock_enable_po, state_po, halted_po, halt_cause_po, cycle_count_po, instr_count_po
    );
    modport slave (
        input  run_pi, step_pi, halt_pi, bp_en_pi, bp_addr_pi, pc_pi, instr_pi, clear_counts_pi,
        output clock_enable_po, state_po, halted_po, halt_cause_po, cycle_count_po, instr_count_po
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step controller: Mealy clock enable for the core, halt on
// external request, PC breakpoint or HALT opcode, plus cycle/instruction counters.
module cpu_run_ctrl #(
    parameter logic [15:0] HALT_OPCODE = 16'hFFFF,
    parameter int          CNT_WIDTH   = 32
) (
    input  logic           CLK_pi,
    input  logic           RESET_pi,
    cpu_run_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_HALTED = 2'b00,
        S_RUN    = 2'b01,
        S_STEP   = 2'b10
    } state_t;

    state_t               state, state_next;
    logic [1:0]           cause, cause_next;
    logic                 bp_skip, bp_skip_next;
    logic                 ce;
    logic                 ext, bp, op;
    logic [CNT_WIDTH-1:0] cyc_cnt, ins_cnt;

    assign ext = bus.halt_pi;
    assign bp  = bus.bp_en_pi && (bus.pc_pi == bus.bp_addr_pi) && !bp_skip;
    assign op  = (bus.instr_pi == HALT_OPCODE);

    always_ff @(posedge CLK_pi or posedge RESET_pi) begin
        if (RESET_pi) begin
            state   <= S_HALTED;
            cause   <= 2'd0;
            bp_skip <= 1'b0;
        end else begin
            state   <= state_next;
            cause   <= cause_next;
            bp_skip <= bp_skip_next;
        end
    end

    always_comb begin
        state_next   = state;
        cause_next   = cause;
        bp_skip_next = bp_skip;
        ce           = 1'b0;
        case (state)
            S_HALTED: begin
                if (bus.run_pi)       state_next = S_RUN;
                else if (bus.step_pi) state_next = S_STEP;
            end
            S_RUN: begin
                ce = !(ext || bp || op);
                if (ext || bp || op) begin
                    state_next = S_HALTED;
                    cause_next = ext ? 2'd1 : (bp ? 2'd2 : 2'd3);
                end
            end
            S_STEP: begin
                // external halt and breakpoint cannot stop a single step
                ce         = !op;
                state_next = S_HALTED;
                cause_next = op ? 2'd3 : 2'd0;
            end
            default: state_next = S_HALTED;
        endcase
        // skip the breakpoint once on resume so the breakpointed instruction executes
        if (state == S_HALTED && state_next != S_HALTED) bp_skip_next = 1'b1;
        else if (ce)                                     bp_skip_next = 1'b0;
    end

    always_ff @(posedge CLK_pi or posedge RESET_pi) begin
        if (RESET_pi) begin
            cyc_cnt <= '0;
            ins_cnt <= '0;
        end else if (bus.clear_counts_pi) begin
            cyc_cnt <= '0;
            ins_cnt <= '0;
        end else begin
            if (state != S_HALTED) cyc_cnt <= cyc_cnt + 1'b1;
            if (ce)                ins_cnt <= ins_cnt + 1'b1;
        end
    end

    assign bus.clock_enable_po = ce;
    assign bus.state_po        = state;
    assign bus.halted_po       = (state == S_HALTED);
    assign bus.halt_cause_po   = cause;
    assign bus.cycle_count_po  = cyc_cnt;
    assign bus.instr_count_po  = ins_cnt;
endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/halt/single-step controller for the 16-bit processor. It generates the processor's clock enable, which drives `clock_enable_pi` of `program_counter` and gates `reg_write_en` and `mem_write_en`, in place of the constant-1 enable. It halts execution on an external request, a PC breakpoint, or a HALT opcode. It also keeps cycle and retired-instruction counters for debug.

## Interface
Parameters:
- `HALT_OPCODE`, default `16'hFFFF`: instruction word that halts the core without executing.
- `CNT_WIDTH`, default 32: width of both performance counters.

Ports:
- `CLK_pi`, in, 1: single clock. All state changes on its rising edge.
- `RESET_pi`, in, 1: asynchronous, active-high reset.
- `run_pi`, in, 1: request free-running execution. Level, sampled each cycle.
- `step_pi`, in, 1: request execution of exactly one instruction.
- `halt_pi`, in, 1: external halt request.
- `bp_en_pi`, in, 1: breakpoint enable.
- `bp_addr_pi`, in, 16: breakpoint PC.
- `pc_pi`, in, 16: current PC, from the `program_counter` output.
- `instr_pi`, in, 16: current instruction, from `instruction_mem`.
- `clear_counts_pi`, in, 1: synchronous clear of both counters.
- `clock_enable_po`, out, 1: processor advance enable.
- `state_po`, out, 2: 00 HALTED, 01 RUN, 10 STEP.
- `halted_po`, out, 1: high when state is HALTED.
- `halt_cause_po`, out, 2: 0 reset/step done, 1 external, 2 breakpoint, 3 HALT opcode.
- `cycle_count_po`, out, CNT_WIDTH: count of non-HALTED cycles.
- `instr_count_po`, out, CNT_WIDTH: count of cycles with `clock_enable_po`=1.

## Operation
Halt conditions, evaluated combinationally:
- `ext` = `halt_pi`.
- `bp` = `bp_en_pi` & (`pc_pi`==`bp_addr_pi`) & !`bp_skip`.
- `op` = (`instr_pi`==`HALT_OPCODE`).

State machine:
- HALTED:
  - `clock_enable_po`=0.
  - `run_pi` → RUN. `run_pi` has priority over `step_pi`.
  - `step_pi` alone → STEP.
  - `halt_pi` is ignored.
- RUN:
  - `clock_enable_po` = !(`ext`|`bp`|`op`).
  - If any halt condition holds: next state HALTED; `halt_cause_po` loads the highest-priority cause (ext > bp > op). The instruction at `pc_pi` is not executed.
- STEP:
  - `clock_enable_po` = !`op`.
  - `ext` and `bp` are ignored.
  - Next state is always HALTED.
  - `halt_cause_po` loads 3 if `op`, else 0.
- `bp_skip` flag:
  - Set on every transition out of HALTED.
  - Cleared after the first cycle in which `clock_enable_po`=1.
  - Purpose: resuming from a breakpoint executes the breakpointed instruction once instead of re-halting.
- HALT opcode is sticky: resuming with `run_pi` or `step_pi` re-halts until the instruction memory contents change or reset.

Counters:
- `cycle_count_po` increments every cycle the state is RUN or STEP.
- `instr_count_po` increments every cycle `clock_enable_po`=1.
- Both wrap modulo 2^CNT_WIDTH.
- `clear_counts_pi` zeroes both counters and has priority over increment in the same cycle.

## Timing
- Reset (asynchronous, immediate):
  - state HALTED, `clock_enable_po`=0, `halted_po`=1, `halt_cause_po`=0.
  - counters 0, `bp_skip`=0.
  - Reset mid-RUN drops `clock_enable_po` in the same cycle, without waiting for a clock edge.
- `clock_enable_po` is Mealy. Within a cycle it depends on state, `pc_pi`, `instr_pi` and `halt_pi`. The halting cycle therefore never advances the PC or commits register or memory writes.
- Run latency: `run_pi` sampled high at edge N → RUN from edge N. `clock_enable_po` can be 1 in cycle N+1.
- Step: exactly one cycle in STEP (at most one enabled cycle), then HALTED. Holding `step_pi` high re-enters STEP every other cycle.
- Halt latency: a condition present in cycle K gives `clock_enable_po`=0 in cycle K and HALTED from edge K.
- Simultaneous `run_pi` and `halt_pi` in HALTED: go to RUN; in the first RUN cycle `ext` halts again with cause 1.
- Counter values are registered and visible the cycle after the counted event.

## Test plan
- Reset then idle 5 cycles:
  - `clock_enable_po`=0, `halted_po`=1, `state_po`=00, `halt_cause_po`=0, counts 0.
  - Assert `RESET_pi` mid-RUN: `clock_enable_po` falls before the next edge.
- `run_pi` pulse, program with no halt source, 10 cycles:
  - `clock_enable_po`=1 for 10 cycles; `instr_count_po`=10 and `cycle_count_po`=10 after the last edge.
  - Then `halt_pi` pulse: enable 0 that cycle, `halt_cause_po`=1, PC frozen.
- Breakpoint at 16'h0004, `bp_en_pi`=1, run from PC 0:
  - Halts with `pc_pi`=0004, `halt_cause_po`=2, `instr_count_po`=4.
  - Next `run_pi`: PC 0004 executes (enable 1); no re-halt at 0004.
- Three `step_pi` pulses from PC 0:
  - Exactly 3 enabled cycles, `instr_count_po`=3, `halt_cause_po`=0 each time.
  - `halt_pi` held high during STEP is ignored.
- `instr_pi`=16'hFFFF at PC 0002, in RUN:
  - Halt with cause 3, `instr_count_po`=2.
  - `step_pi` afterwards: enable stays 0, cause 3.
- Counter wrap with CNT_WIDTH=4: 17 RUN cycles → `cycle_count_po`=1.
  - `clear_counts_pi` asserted on an incrementing cycle → count 0.
